// File: rtl/rf_hazard_scoreboard.sv
// Issue scheduler: tracks in-flight register writes across EXE/MEM/WB and gives ID a stall or
// a one-hot bypass source per operand. Define SCOREBOARD_PERF_EN to add the stall-cycle counter.
module rf_hazard_scoreboard #(
  parameter int unsigned RF_ADDR_W  = 5,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDR_W-1:0]  id_r_addr1,
  input  logic [RF_ADDR_W-1:0]  id_r_addr2,
  input  logic                  id_w_en,
  input  logic [RF_ADDR_W-1:0]  id_w_addr,
  input  logic [2:0]            id_w_valid_stage,
  input  logic                  exe_in,
  input  logic                  mem_in,
  input  logic                  wb_in,
  input  logic                  wb_out,
  output logic                  id_stall,
  output logic [2:0]            byp_sel1,
  output logic [2:0]            byp_sel2,
  output logic [PERF_CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] STG_EXE = 3'b001;
  localparam logic [2:0] STG_MEM = 3'b010;
  localparam logic [2:0] STG_WB  = 3'b100;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] waddr;
    logic [2:0]           rdy_stage;
  } slot_t;

  slot_t s_exe_q, s_exe_d;
  slot_t s_mem_q, s_mem_d;
  slot_t s_wb_q,  s_wb_d;

  logic [3:0] op1_res;
  logic [3:0] op2_res;

  // Slot chain advance; each slot reads only the pre-update values of its predecessor.
  always_comb begin
    s_exe_d = s_exe_q;
    s_mem_d = s_mem_q;
    s_wb_d  = s_wb_q;

    if (exe_in) begin
      s_exe_d.valid     = id_w_en && (id_w_addr != '0);
      s_exe_d.waddr     = id_w_addr;
      s_exe_d.rdy_stage = id_w_valid_stage;
    end else if (mem_in) begin
      s_exe_d.valid = 1'b0;
    end

    if (mem_in) begin
      s_mem_d = s_exe_q;
    end else if (wb_in) begin
      s_mem_d.valid = 1'b0;
    end

    if (wb_in) begin
      s_wb_d = s_mem_q;
    end else if (wb_out) begin
      s_wb_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_exe_q <= '0;
      s_mem_q <= '0;
      s_wb_q  <= '0;
    end else begin
      s_exe_q <= s_exe_d;
      s_mem_q <= s_mem_d;
      s_wb_q  <= s_wb_d;
    end
  end

  // Returns {hazard, sel}; the youngest matching slot decides, so older ready copies never mask it.
  function automatic logic [3:0] resolve(input logic [RF_ADDR_W-1:0] addr,
                                         input slot_t e, input slot_t m, input slot_t w);
    logic [3:0] r;
    r = 4'b0000;
    if (addr != '0) begin
      if (e.valid && (e.waddr == addr)) begin
        r = (e.rdy_stage == STG_EXE) ? {1'b0, STG_EXE} : 4'b1000;
      end else if (m.valid && (m.waddr == addr)) begin
        r = ((m.rdy_stage == STG_EXE) || (m.rdy_stage == STG_MEM)) ? {1'b0, STG_MEM} : 4'b1000;
      end else if (w.valid && (w.waddr == addr)) begin
        r = {1'b0, STG_WB};
      end
    end
    return r;
  endfunction

  always_comb begin
    op1_res  = resolve(id_r_addr1, s_exe_q, s_mem_q, s_wb_q);
    op2_res  = resolve(id_r_addr2, s_exe_q, s_mem_q, s_wb_q);
    id_stall = id_valid && (op1_res[3] || op2_res[3]);
    byp_sel1 = id_valid ? op1_res[2:0] : 3'b000;
    byp_sel2 = id_valid ? op2_res[2:0] : 3'b000;
  end

`ifdef SCOREBOARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  // ID must never hand an instruction to EXE while it is being told to stall.
  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (reset) !(exe_in && id_stall));

endmodule
